// File: rtl/tracker_sig_qualifier.sv
// Conditions the raw GPS-fix and beacon-force inputs and drives the 2-bit mode
// code (00 beacon, 01 toggle, 11 GPS held) into the downstream tracker FSM.
module tracker_sig_qualifier #(
    parameter int DEB_CYCLES  = 4,
    parameter int LOSS_CYCLES = 16,
    parameter int HOLDOFF     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       gps_fix_raw,
    input  logic       beacon_raw,
    output logic [1:0] code,
    output logic       gps_locked,
    output logic       lost_pulse,
    output logic       fix_filt
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int LW = $clog2(LOSS_CYCLES + 1);
    localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [LW-1:0] LOSS_MAX = LW'(LOSS_CYCLES);
    localparam logic [HW-1:0] HOLD_LD  = HW'(HOLDOFF);

    typedef enum logic [1:0] {
        BEACON = 2'd0,
        SW_GPS = 2'd1,
        GPS    = 2'd2,
        SW_BCN = 2'd3
    } state_t;

    state_t          state;
    logic            fix_s1, fix_s2;
    logic            bcn_s1, bcn_s2;
    logic [DW-1:0]   fix_cnt, bcn_cnt;
    logic            bcn_filt, bcn_dly;
    logic            bcn_rise;
    logic [LW-1:0]   loss_cnt;
    logic [HW-1:0]   hold_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fix_s1 <= 1'b0;
            fix_s2 <= 1'b0;
            bcn_s1 <= 1'b0;
            bcn_s2 <= 1'b0;
        end else begin
            fix_s1 <= gps_fix_raw;
            fix_s2 <= fix_s1;
            bcn_s1 <= beacon_raw;
            bcn_s2 <= bcn_s1;
        end
    end

    // The counter only runs while the synced level disagrees with the filtered one,
    // so it can never exceed DEB_CYCLES-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fix_cnt  <= '0;
            fix_filt <= 1'b0;
        end else if (fix_s2 == fix_filt) begin
            fix_cnt <= '0;
        end else if (fix_cnt == DEB_LAST) begin
            fix_filt <= ~fix_filt;
            fix_cnt  <= '0;
        end else begin
            fix_cnt <= fix_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcn_cnt  <= '0;
            bcn_filt <= 1'b0;
            bcn_dly  <= 1'b0;
        end else begin
            bcn_dly <= bcn_filt;
            if (bcn_s2 == bcn_filt) begin
                bcn_cnt <= '0;
            end else if (bcn_cnt == DEB_LAST) begin
                bcn_filt <= ~bcn_filt;
                bcn_cnt  <= '0;
            end else begin
                bcn_cnt <= bcn_cnt + 1'b1;
            end
        end
    end

    assign bcn_rise = bcn_filt & ~bcn_dly;

    // Outputs are registered from the next state, so code always reflects the
    // state the FSM has just entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= BEACON;
            code       <= 2'b00;
            gps_locked <= 1'b0;
            lost_pulse <= 1'b0;
            loss_cnt   <= '0;
            hold_cnt   <= '0;
        end else begin
            lost_pulse <= 1'b0;
            case (state)
                BEACON: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                    if (fix_filt && (hold_cnt == '0) && !bcn_rise) begin
                        state <= SW_GPS;
                        code  <= 2'b01;
                    end
                end
                SW_GPS: begin
                    state      <= GPS;
                    code       <= 2'b11;
                    gps_locked <= 1'b1;
                    loss_cnt   <= '0;
                end
                GPS: begin
                    // Beacon force takes priority; a loss already counted out is
                    // declared even if the fix has just come back.
                    if (bcn_rise) begin
                        state      <= SW_BCN;
                        code       <= 2'b01;
                        gps_locked <= 1'b0;
                    end else if (loss_cnt == LOSS_MAX) begin
                        state      <= SW_BCN;
                        code       <= 2'b01;
                        gps_locked <= 1'b0;
                        lost_pulse <= 1'b1;
                    end else if (fix_filt) begin
                        loss_cnt <= '0;
                    end else begin
                        loss_cnt <= loss_cnt + 1'b1;
                    end
                end
                SW_BCN: begin
                    state    <= BEACON;
                    code     <= 2'b00;
                    hold_cnt <= HOLD_LD;
                    loss_cnt <= '0;
                end
                default: begin
                    state      <= BEACON;
                    code       <= 2'b00;
                    gps_locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tracker_sig_qualifier.sv
// Randomised and directed bench for tracker_sig_qualifier, checked cycle by cycle
// against a window/age based behavioural model of the qualifier.
module tb_tracker_sig_qualifier;

    localparam int DEB  = 4;
    localparam int LOSS = 16;
    localparam int HOLD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       gps_fix_raw = 1'b0;
    logic       beacon_raw = 1'b0;
    logic [1:0] code;
    logic       gps_locked;
    logic       lost_pulse;
    logic       fix_filt;

    int checks = 0;
    int errors = 0;

    tracker_sig_qualifier #(
        .DEB_CYCLES (DEB),
        .LOSS_CYCLES(LOSS),
        .HOLDOFF    (HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .gps_fix_raw(gps_fix_raw),
        .beacon_raw (beacon_raw),
        .code       (code),
        .gps_locked (gps_locked),
        .lost_pulse (lost_pulse),
        .fix_filt   (fix_filt)
    );

    always #5 clk = ~clk;

    typedef enum {M_BCN, M_TOGPS, M_GPS, M_TOBCN} mode_t;

    bit    fs1, fs2, bs1, bs2;
    bit    m_fix, m_bcn, m_bcn_prev;
    bit    fhist[$];
    bit    bhist[$];
    mode_t mode;
    int    low_run;
    int    beacon_age;
    bit    m_lost;
    logic [1:0] prev_code;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // A filtered level flips once the last DEB synced samples all disagree with it.
    function automatic bit all_differ(input bit h[$], input bit lvl);
        if (h.size() < DEB) return 1'b0;
        for (int i = 0; i < DEB; i++) begin
            if (h[h.size() - 1 - i] == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        fs1 = 0; fs2 = 0; bs1 = 0; bs2 = 0;
        m_fix = 0; m_bcn = 0; m_bcn_prev = 0;
        fhist.delete();
        bhist.delete();
        mode = M_BCN;
        low_run = 0;
        beacon_age = HOLD;
        m_lost = 0;
        prev_code = 2'b00;
    endtask

    task automatic model_step();
        bit rise;
        mode_t nxt;
        if (!rst) begin
            model_reset();
            return;
        end
        rise = m_bcn && !m_bcn_prev;
        nxt = mode;
        m_lost = 0;
        case (mode)
            M_BCN: begin
                if (m_fix && beacon_age >= HOLD && !rise) nxt = M_TOGPS;
                if (beacon_age < HOLD) beacon_age++;
            end
            M_TOGPS: begin
                nxt = M_GPS;
                low_run = 0;
            end
            M_GPS: begin
                if (rise) nxt = M_TOBCN;
                else if (low_run >= LOSS) begin
                    nxt = M_TOBCN;
                    m_lost = 1;
                end else low_run = m_fix ? 0 : low_run + 1;
            end
            M_TOBCN: begin
                nxt = M_BCN;
                beacon_age = 0;
                low_run = 0;
            end
        endcase
        mode = nxt;
        fhist.push_back(fs2);
        bhist.push_back(bs2);
        if (fhist.size() > DEB) void'(fhist.pop_front());
        if (bhist.size() > DEB) void'(bhist.pop_front());
        if (all_differ(fhist, m_fix)) m_fix = ~m_fix;
        m_bcn_prev = m_bcn;
        if (all_differ(bhist, m_bcn)) m_bcn = ~m_bcn;
        fs2 = fs1; fs1 = gps_fix_raw;
        bs2 = bs1; bs1 = beacon_raw;
    endtask

    function automatic logic [1:0] exp_code();
        case (mode)
            M_GPS:   return 2'b11;
            M_TOGPS: return 2'b01;
            M_TOBCN: return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_output("code", code, exp_code());
        check_output("gps_locked", gps_locked, mode == M_GPS);
        check_output("lost_pulse", lost_pulse, m_lost);
        check_output("fix_filt", fix_filt, m_fix);
        check_output("no_code10", code == 2'b10, 1'b0);
        check_output("toggle_gap", (code == 2'b01) && (prev_code == 2'b01), 1'b0);
        prev_code = code;
    endtask

    task automatic apply_stimulus(input bit fix, input bit bcn, input int cycles);
        gps_fix_raw = fix;
        beacon_raw  = bcn;
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b0;
        #1;
        model_reset();
        check_output("rst_code", code, 2'b00);
        check_output("rst_locked", gps_locked, 1'b0);
        check_output("rst_lost", lost_pulse, 1'b0);
        for (int i = 0; i < cycles; i++) begin
            gps_fix_raw = $urandom_range(0, 1);
            beacon_raw  = $urandom_range(0, 1);
            tick();
        end
        gps_fix_raw = 1'b0;
        beacon_raw  = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        int n;
        int lost_seen;
        int seen11;
        model_reset();
        @(negedge clk);
        apply_reset(6);
        apply_stimulus(0, 0, 12);

        // Acquire: fix edge to first 01 must take 2 + DEB + 1 cycles.
        gps_fix_raw = 1'b1;
        n = 0;
        while (code != 2'b01 && n < 40) begin
            tick();
            n++;
        end
        check_output("acq_latency", n, 2 + DEB + 1);
        apply_stimulus(1, 0, 3);
        check_output("acq_locked", gps_locked, 1'b1);

        // Loss just short of the timeout, then a full loss.
        apply_stimulus(0, 0, 15);
        apply_stimulus(1, 0, 10);
        check_output("loss15_held", code, 2'b11);
        lost_seen = 0;
        gps_fix_raw = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (lost_pulse) lost_seen++;
            if (i == 20) gps_fix_raw = 1'b1;
        end
        check_output("loss_count", lost_seen, 1);
        apply_stimulus(1, 0, 20);
        check_output("reacq_locked", gps_locked, 1'b1);

        // Beacon force timed to land while the loss counter sits at 15.
        gps_fix_raw = 1'b0;
        n = 0;
        while (!(mode == M_GPS && low_run == 9) && n < 40) begin
            tick();
            n++;
        end
        check_output("force_setup", n < 40, 1'b1);
        beacon_raw = 1'b1;
        lost_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (lost_pulse) lost_seen++;
        end
        check_output("force_no_lost", lost_seen, 0);
        check_output("force_beacon", code, 2'b00);
        apply_stimulus(0, 0, 20);

        // Async reset while in SW_GPS aborts the toggle at once.
        gps_fix_raw = 1'b1;
        n = 0;
        while (code != 2'b01 && n < 60) begin
            tick();
            n++;
        end
        check_output("swgps_reached", code, 2'b01);
        rst = 1'b0;
        gps_fix_raw = 1'b0;
        #1;
        model_reset();
        check_output("abort_code", code, 2'b00);
        apply_stimulus(0, 0, 2);
        rst = 1'b1;
        seen11 = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (code == 2'b11) seen11++;
        end
        check_output("abort_no11", seen11, 0);

        // Random held-level segments on both raw inputs.
        for (int seg = 0; seg < 120; seg++) begin
            bit f;
            bit b;
            f = ($urandom_range(0, 3) != 0);
            b = ($urandom_range(0, 5) == 0);
            apply_stimulus(f, b, $urandom_range(1, 30));
            if ($urandom_range(0, 60) == 0) apply_reset($urandom_range(1, 4));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
